// File: rtl/key_action.sv
// key_action: turns keyboard key levels into frame-aligned movement, jump and
// restart actions for the player physics update.
module key_action #(
  parameter int MAX_HOLD  = 8,
  parameter int JUMPS_MAX = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [3:0]                     keys,
  input  logic                           frame_tick,
  input  logic                           on_ground,
  output logic                           move_left,
  output logic                           move_right,
  output logic                           jump_start,
  output logic                           jump_hold,
  output logic                           restart,
  output logic [$clog2(JUMPS_MAX+1)-1:0] jumps_left
);

  localparam int JL_W = $clog2(JUMPS_MAX + 1);
  localparam int HC_W = $clog2(MAX_HOLD + 1);
  localparam logic [JL_W-1:0] JUMPS_FULL = JL_W'(JUMPS_MAX);
  localparam logic [HC_W-1:0] HOLD_LIMIT = HC_W'(MAX_HOLD);

  localparam int KEY_R = 3;
  localparam int KEY_A = 2;
  localparam int KEY_D = 1;
  localparam int KEY_W = 0;

  typedef enum logic {
    IDLE,
    HOLD
  } jump_state_t;

  logic [3:0]      keys_meta;
  logic [3:0]      keys_sync;
  logic [3:0]      keys_prev;
  logic [3:0]      key_rise;
  logic            w_pend;
  logic            r_pend;
  logic            last_dir_right;
  logic            dir_right_now;
  logic            w_now;
  logic            r_now;
  logic [JL_W-1:0] eff_jumps;
  logic            jump_ok;

  jump_state_t     state;
  jump_state_t     state_nxt;
  logic [HC_W-1:0] hold_cnt;
  logic [HC_W-1:0] hold_cnt_nxt;
  logic            move_left_nxt;
  logic            move_right_nxt;
  logic            jump_start_nxt;
  logic            jump_hold_nxt;
  logic            restart_nxt;
  logic [JL_W-1:0] jumps_left_nxt;

  // Edges seen on the tick cycle itself are folded in here so they are consumed by that tick.
  always_comb begin
    key_rise = keys_sync & ~keys_prev;
    w_now    = w_pend | key_rise[KEY_W];
    r_now    = r_pend | key_rise[KEY_R];
    if (key_rise[KEY_D]) begin
      dir_right_now = 1'b1;
    end else if (key_rise[KEY_A]) begin
      dir_right_now = 1'b0;
    end else begin
      dir_right_now = last_dir_right;
    end
    eff_jumps = on_ground ? JUMPS_FULL : jumps_left;
    jump_ok   = w_now && (eff_jumps != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_meta      <= '0;
      keys_sync      <= '0;
      keys_prev      <= '0;
      w_pend         <= 1'b0;
      r_pend         <= 1'b0;
      last_dir_right <= 1'b0;
    end else begin
      keys_meta      <= keys;
      keys_sync      <= keys_meta;
      keys_prev      <= keys_sync;
      last_dir_right <= dir_right_now;
      if (frame_tick) begin
        w_pend <= 1'b0;
        r_pend <= 1'b0;
      end else begin
        if (key_rise[KEY_W]) w_pend <= 1'b1;
        if (key_rise[KEY_R]) r_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    hold_cnt_nxt   = hold_cnt;
    move_left_nxt  = move_left;
    move_right_nxt = move_right;
    jump_start_nxt = 1'b0;
    jump_hold_nxt  = jump_hold;
    restart_nxt    = 1'b0;
    jumps_left_nxt = jumps_left;

    if (frame_tick) begin
      unique case ({keys_sync[KEY_A], keys_sync[KEY_D]})
        2'b10: begin
          move_left_nxt  = 1'b1;
          move_right_nxt = 1'b0;
        end
        2'b01: begin
          move_left_nxt  = 1'b0;
          move_right_nxt = 1'b1;
        end
        2'b11: begin
          move_left_nxt  = ~dir_right_now;
          move_right_nxt = dir_right_now;
        end
        default: begin
          move_left_nxt  = 1'b0;
          move_right_nxt = 1'b0;
        end
      endcase

      // Restart wins over any pending jump press in the same frame.
      if (r_now) begin
        restart_nxt    = 1'b1;
        state_nxt      = IDLE;
        hold_cnt_nxt   = '0;
        jump_hold_nxt  = 1'b0;
        jumps_left_nxt = JUMPS_FULL;
      end else if (jump_ok) begin
        jump_start_nxt = 1'b1;
        jumps_left_nxt = eff_jumps - JL_W'(1);
        state_nxt      = HOLD;
        hold_cnt_nxt   = HC_W'(1);
        jump_hold_nxt  = 1'b1;
      end else begin
        jumps_left_nxt = eff_jumps;
        unique case (state)
          HOLD: begin
            if (!keys_sync[KEY_W] || (hold_cnt == HOLD_LIMIT)) begin
              state_nxt     = IDLE;
              jump_hold_nxt = 1'b0;
            end else begin
              hold_cnt_nxt = hold_cnt + HC_W'(1);
            end
          end
          default: begin
            jump_hold_nxt = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
      jump_start <= 1'b0;
      jump_hold  <= 1'b0;
      restart    <= 1'b0;
      jumps_left <= JUMPS_FULL;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      move_left  <= move_left_nxt;
      move_right <= move_right_nxt;
      jump_start <= jump_start_nxt;
      jump_hold  <= jump_hold_nxt;
      restart    <= restart_nxt;
      jumps_left <= jumps_left_nxt;
    end
  end

endmodule

// File: tb/tb_key_action.sv
// tb_key_action: randomized scoreboard bench for key_action; a history-based
// reference model predicts the outputs after every frame tick.
module tb_key_action;

  localparam int MAX_HOLD  = 8;
  localparam int JUMPS_MAX = 2;
  localparam int JL_W      = $clog2(JUMPS_MAX + 1);
  localparam int HIST_LEN  = 65536;

  logic            clk        = 1'b0;
  logic            rst_n      = 1'b0;
  logic [3:0]      keys       = 4'b0000;
  logic            frame_tick = 1'b0;
  logic            on_ground  = 1'b1;
  logic            move_left;
  logic            move_right;
  logic            jump_start;
  logic            jump_hold;
  logic            restart;
  logic [JL_W-1:0] jumps_left;

  key_action #(
    .MAX_HOLD (MAX_HOLD),
    .JUMPS_MAX(JUMPS_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .keys      (keys),
    .frame_tick(frame_tick),
    .on_ground (on_ground),
    .move_left (move_left),
    .move_right(move_right),
    .jump_start(jump_start),
    .jump_hold (jump_hold),
    .restart   (restart),
    .jumps_left(jumps_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ml;
    int mr;
    int js;
    int jh;
    int rs;
    int jl;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       last_exp;
  int         checks = 0;
  int         errors = 0;
  int         js_cnt = 0;
  int         jh_cnt = 0;
  int         rs_cnt = 0;

  logic [3:0] hist [HIST_LEN];
  int         cyc       = 0;
  int         rst_base  = 0;
  int         last_tick = 0;
  bit         tick_seen = 1'b0;
  int         m_jl      = JUMPS_MAX;
  int         m_frames  = 0;
  bit         m_active  = 1'b0;

  int         tick_period = 16;
  int         tick_cnt    = 0;
  bit         tick_en     = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Key levels as the design sees them after synchronization; nothing before reset release counts.
  function automatic logic [3:0] key_at(input int i);
    if (i < 0 || i < rst_base) return 4'b0000;
    return hist[i];
  endfunction

  task automatic model_reset();
    m_jl      = JUMPS_MAX;
    m_frames  = 0;
    m_active  = 1'b0;
    tick_seen = 1'b0;
    exp_q.delete();
    last_exp = '{0, 0, 0, 0, 0, JUMPS_MAX};
  endtask

  task automatic model_tick(input int e);
    logic [3:0] cur;
    logic [3:0] prv;
    logic [3:0] rise;
    logic [3:0] lvl;
    bit         w_ev;
    bit         r_ev;
    bit         dir_right;
    int         eff;
    exp_t       x;
    w_ev = 1'b0;
    r_ev = 1'b0;
    for (int j = last_tick + 1; j <= e; j++) begin
      cur  = key_at(j - 2);
      prv  = key_at(j - 3);
      rise = cur & ~prv;
      if (rise[0]) w_ev = 1'b1;
      if (rise[3]) r_ev = 1'b1;
    end
    dir_right = 1'b0;
    for (int j = e; j >= rst_base; j--) begin
      cur  = key_at(j - 2);
      prv  = key_at(j - 3);
      rise = cur & ~prv;
      if (rise[1]) begin
        dir_right = 1'b1;
        break;
      end else if (rise[2]) begin
        dir_right = 1'b0;
        break;
      end
    end
    lvl  = key_at(e - 2);
    x.ml = (lvl[2] && (!lvl[1] || !dir_right)) ? 1 : 0;
    x.mr = (lvl[1] && (!lvl[2] || dir_right)) ? 1 : 0;
    x.js = 0;
    x.rs = 0;
    if (r_ev) begin
      x.rs     = 1;
      m_active = 1'b0;
      m_frames = 0;
      m_jl     = JUMPS_MAX;
    end else begin
      eff = on_ground ? JUMPS_MAX : m_jl;
      if (w_ev && eff > 0) begin
        x.js     = 1;
        m_jl     = eff - 1;
        m_active = 1'b1;
        m_frames = 1;
      end else begin
        m_jl = eff;
        if (m_active) begin
          if (!lvl[0] || m_frames == MAX_HOLD) m_active = 1'b0;
          else m_frames++;
        end
      end
    end
    x.jh = m_active ? 1 : 0;
    x.jl = m_jl;
    exp_q.push_back(x);
    last_tick = e;
  endtask

  initial forever begin
    @(posedge clk);
    hist[cyc] = keys;
    if (!rst_n) begin
      model_reset();
      rst_base  = cyc + 1;
      last_tick = cyc;
    end else begin
      tick_seen = frame_tick;
      if (frame_tick) model_tick(cyc);
    end
    cyc++;
  end

  initial forever begin
    @(negedge rst_n);
    model_reset();
  end

  initial forever begin
    @(negedge clk);
    if (tick_en && rst_n) begin
      if (tick_cnt >= tick_period - 1) begin
        frame_tick = 1'b1;
        tick_cnt   = 0;
      end else begin
        frame_tick = 1'b0;
        tick_cnt++;
      end
    end else begin
      frame_tick = 1'b0;
      tick_cnt   = 0;
    end
  end

  task automatic compare_outputs(input string tag, input exp_t e, input bit with_pulses);
    checkOutput({tag, "_move_left"}, move_left, e.ml);
    checkOutput({tag, "_move_right"}, move_right, e.mr);
    checkOutput({tag, "_jump_start"}, jump_start, with_pulses ? e.js : 0);
    checkOutput({tag, "_jump_hold"}, jump_hold, e.jh);
    checkOutput({tag, "_restart"}, restart, with_pulses ? e.rs : 0);
    checkOutput({tag, "_jumps_left"}, jumps_left, e.jl);
  endtask

  // Monitor: the cycle after every tick presents a new action set; all other cycles must hold.
  initial forever begin
    @(negedge clk);
    if (rst_n && tick_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard_underflow: got 0 entries, expected 1 (t=%0t)", $time);
      end else begin
        last_exp = exp_q.pop_front();
        compare_outputs("tick", last_exp, 1'b1);
        js_cnt += int'(jump_start);
        jh_cnt += int'(jump_hold);
        rs_cnt += int'(restart);
      end
    end else begin
      compare_outputs("hold", last_exp, 1'b0);
    end
  end

  task automatic applyStimulus(input logic [3:0] k, input logic g, input int ncycles);
    keys      = k;
    on_ground = g;
    repeat (ncycles) @(negedge clk);
  endtask

  task automatic clear_counts();
    js_cnt = 0;
    jh_cnt = 0;
    rs_cnt = 0;
  endtask

  initial begin
    logic [3:0] rk;
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    tick_en = 1'b1;

    $display("[TB] right held");
    applyStimulus(4'b0010, 1'b1, 3 * 16);
    checkOutput("right_move_right", move_right, 1);
    checkOutput("right_move_left", move_left, 0);
    checkOutput("right_jumps_left", jumps_left, 2);

    $display("[TB] direction sequence");
    applyStimulus(4'b0100, 1'b1, 24);
    checkOutput("dir1_left", move_left, 1);
    applyStimulus(4'b0110, 1'b1, 24);
    checkOutput("dir2_right", move_right, 1);
    checkOutput("dir2_not_left", move_left, 0);
    applyStimulus(4'b0100, 1'b1, 24);
    checkOutput("dir3_left", move_left, 1);

    $display("[TB] short jump tap");
    applyStimulus(4'b0000, 1'b1, 32);
    clear_counts();
    applyStimulus(4'b0001, 1'b1, 3);
    applyStimulus(4'b0000, 1'b1, 40);
    checkOutput("tap_jump_starts", js_cnt, 1);
    checkOutput("tap_hold_frames", jh_cnt, 1);

    $display("[TB] long hold");
    clear_counts();
    applyStimulus(4'b0001, 1'b1, 20 * 16);
    applyStimulus(4'b0000, 1'b1, 32);
    checkOutput("long_jump_starts", js_cnt, 1);
    checkOutput("long_hold_frames", jh_cnt, MAX_HOLD);

    $display("[TB] air budget");
    applyStimulus(4'b0000, 1'b0, 32);
    clear_counts();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0001, 1'b0, 3);
      applyStimulus(4'b0000, 1'b0, 40);
    end
    checkOutput("air_jump_starts", js_cnt, 2);
    checkOutput("air_jumps_left", jumps_left, 0);

    $display("[TB] restart with jump");
    applyStimulus(4'b0000, 1'b1, 32);
    clear_counts();
    applyStimulus(4'b1001, 1'b1, 3);
    applyStimulus(4'b0000, 1'b1, 40);
    checkOutput("rst_restarts", rs_cnt, 1);
    checkOutput("rst_jump_starts", js_cnt, 0);
    checkOutput("rst_jumps_left", jumps_left, JUMPS_MAX);
    checkOutput("rst_jump_hold", jump_hold, 0);

    $display("[TB] frames paused");
    tick_en = 1'b0;
    applyStimulus(4'b0101, 1'b1, 4);
    applyStimulus(4'b0000, 1'b1, 30);
    tick_en = 1'b1;
    applyStimulus(4'b0000, 1'b1, 40);

    $display("[TB] async reset mid-hold");
    applyStimulus(4'b0011, 1'b1, 3 * 16);
    checkOutput("mid_hold_jump_hold", jump_hold, 1);
    #2;
    rst_n   = 1'b0;
    tick_en = 1'b0;
    #1;
    checkOutput("areset_move_left", move_left, 0);
    checkOutput("areset_move_right", move_right, 0);
    checkOutput("areset_jump_start", jump_start, 0);
    checkOutput("areset_jump_hold", jump_hold, 0);
    checkOutput("areset_restart", restart, 0);
    checkOutput("areset_jumps_left", jumps_left, JUMPS_MAX);
    repeat (3) @(negedge clk);
    keys    = 4'b0000;
    rst_n   = 1'b1;
    tick_en = 1'b1;
    applyStimulus(4'b0000, 1'b1, 20);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) tick_period = $urandom_range(3, 20);
      rk = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 11) == 0) rk[3] = 1'b1;
      applyStimulus(rk, 1'($urandom_range(0, 1)), $urandom_range(1, 12));
    end

    tick_period = 16;
    applyStimulus(4'b0000, 1'b1, 40);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
